reduce_mod_pipe: RTL and testbench

REDUCE_MOD_PIPE -- requirements
Module: reduce_mod_pipe

---
 rtl/reduce_mod_pipe.sv | 87 ++++++++
 tb/tb_reduce_mod_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reduce_mod_pipe.sv
// Three-stage pipelined reduction modulo P = 2^W - C with valid/ready flow control.
// Two folds using 2^W == C (mod P), then an optional final subtract of P.
module reduce_mod_pipe #(
  parameter int W     = 130,
  parameter int C     = 5,
  parameter int IN_W  = 258,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_value,
  input  logic             in_full,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_value,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);
  // Fold widths: hi part times C (C < 256) adds at most 8 bits, plus one carry.
  localparam int H0  = IN_W - W;
  localparam int S1W = ((W > H0 + 8) ? W : H0 + 8) + 1;
  localparam int H1  = S1W - W;
  localparam int S2W = ((W > H1 + 8) ? W : H1 + 8) + 1;
  localparam logic [S2W-1:0] P = (S2W'(1) << W) - S2W'(C);

  logic [3:1]       vld_pipe, vld_nx;
  logic [4:1]       en;
  logic             take;
  logic [S1W-1:0]   s1, s1_nx;
  logic [S2W-1:0]   s2, s2_nx;
  logic [W:0]       s3, s3_nx;
  logic             full1, full2;
  logic [TAG_W-1:0] tag1, tag2, tag3;

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin
    en[4] = out_ready;
    for (int k = 3; k >= 1; k--) en[k] = !vld_pipe[k] || en[k+1];
  end

  assign in_ready = !reset && !flush && en[1];
  assign take     = in_valid && in_ready;

  assign s1_nx = S1W'(in_value[W-1:0]) + S1W'(C) * S1W'(in_value[IN_W-1:W]);
  assign s2_nx = S2W'(s1[W-1:0]) + S2W'(C) * S2W'(s1[S1W-1:W]);
  assign s3_nx = (full2 && s2 >= P) ? (W+1)'(s2 - P) : (W+1)'(s2);

  always_comb begin
    vld_nx = vld_pipe;
    if (flush) vld_nx = '0;
    else begin
      if (en[1]) vld_nx[1] = take;
      if (en[2]) vld_nx[2] = vld_pipe[1];
      if (en[3]) vld_nx[3] = vld_pipe[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      occupancy <= '0;
      s1 <= '0; s2 <= '0; s3 <= '0;
      full1 <= 1'b0; full2 <= 1'b0;
      tag1 <= '0; tag2 <= '0; tag3 <= '0;
    end else begin
      vld_pipe  <= vld_nx;
      occupancy <= 2'(vld_nx[1]) + 2'(vld_nx[2]) + 2'(vld_nx[3]);
      if (take) begin
        s1 <= s1_nx; full1 <= in_full; tag1 <= in_tag;
      end
      if (en[2]) begin
        s2 <= s2_nx; full2 <= full1; tag2 <= tag1;
      end
      if (en[3]) begin
        s3 <= s3_nx; tag3 <= tag2;
      end
    end
  end

  assign out_valid = vld_pipe[3];
  assign out_value = s3;
  assign out_tag   = tag3;
endmodule

// File: tb/tb_reduce_mod_pipe.sv
// Bench for reduce_mod_pipe: directed latency/stall/flush/reset steps plus a random
// stream scored against a queue model that reduces with plain wide modulo arithmetic.
module tb_reduce_mod_pipe;
  localparam int W = 130, C = 5, IN_W = 258, TAG_W = 4;
  localparam logic [259:0] PM    = (260'(1) << W) - 260'(C);
  localparam logic [259:0] BOUND = (260'(1) << W) + 260'(8 * C);

  logic             clk, reset, flush, in_valid, in_ready, in_full;
  logic [IN_W-1:0]  in_value;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_valid, out_ready;
  logic [W:0]       out_value;
  logic [1:0]       occupancy;

  reduce_mod_pipe #(.W(W), .C(C), .IN_W(IN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_full(in_full), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_value(out_value), .out_tag(out_tag), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [259:0]     val;
    logic             full;
    logic [TAG_W-1:0] tag;
  } item_t;
  item_t q[$];

  task automatic chk(input string name, input logic [259:0] got, input logic [259:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [259:0] rand_val();
    logic [287:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    return 260'(t[257:0]);
  endfunction

  // Scoreboard: handshakes seen at the falling edge complete on the next rising edge.
  item_t e;
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (out_valid && out_ready) begin
        chk("q_nonempty", 260'(q.size() > 0), 260'(1));
        if (q.size() > 0) begin
          e = q.pop_front();
          if (e.full) chk("full_val", 260'(out_value), e.val % PM);
          else begin
            chk("part_cong", 260'(out_value) % PM, e.val % PM);
            chk("part_bound", 260'(260'(out_value) < BOUND), 260'(1));
          end
          chk("tag", 260'(out_tag), 260'(e.tag));
        end
      end
      if (in_valid && in_ready) q.push_back('{260'(in_value), in_full, in_tag});
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [259:0] vals [4];
  logic [259:0] exps [4];
  logic [259:0] v, ones;
  int accepted;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_full = 1'b1;
    in_value = '0; in_tag = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 260'(out_valid), 0);
    chk("rst_occ", 260'(occupancy), 0);
    chk("rst_in_ready", 260'(in_ready), 0);
    chk("rst_out_value", 260'(out_value), 0);
    chk("rst_out_tag", 260'(out_tag), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("first_in_ready", 260'(in_ready), 1);

    // Back-to-back full reductions with exact 3-cycle latency.
    vals[0] = PM; vals[1] = PM + 7; vals[2] = (260'(3) << W) + 1; vals[3] = 0;
    exps[0] = 0;  exps[1] = 7;      exps[2] = 16;                 exps[3] = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_value = vals[c][257:0]; in_tag = TAG_W'(c + 1);
      end else in_valid = 1'b0;
      #1;
      if (c < 4) chk("b2b_in_ready", 260'(in_ready), 1);
      if (c < 3) chk("lat_early", 260'(out_valid), 0);
      else begin
        chk("b2b_valid", 260'(out_valid), 1);
        chk("b2b_value", 260'(out_value), exps[c-3]);
        chk("b2b_tag", 260'(out_tag), 260'(c - 2));
      end
      step();
    end

    // Partial vs full reduction of P, then the all-ones operand.
    for (int k = 0; k < 3; k++) begin
      ones = (260'(1) << 258) - 1;
      v = (k == 2) ? ones : PM;
      in_valid = 1'b1; in_value = v[257:0]; in_full = (k != 0); in_tag = TAG_W'(k + 5);
      step();
      in_valid = 1'b0;
      step(); step();
      chk("single_valid", 260'(out_valid), 1);
      if (k == 0) chk("partial_P", 260'(out_value), PM);
      else if (k == 1) chk("full_P", 260'(out_value), 0);
      else begin
        chk("all_ones", 260'(out_value), ones % PM);
        chk("all_ones_lt_P", 260'(260'(out_value) < PM), 1);
      end
      step();
    end
    in_full = 1'b1;

    // Stall: out_ready low for 6 cycles with continuous input.
    out_ready = 1'b0; accepted = 0;
    for (int c = 0; c < 6; c++) begin
      v = rand_val();
      if (c == 0) exps[0] = v % PM;
      in_valid = 1'b1; in_value = v[257:0]; in_tag = TAG_W'(c + 8);
      #1;
      if (in_ready) accepted++;
      if (c >= 3) begin
        chk("stall_in_ready", 260'(in_ready), 0);
        chk("stall_occ", 260'(occupancy), 3);
        chk("stall_held", 260'(out_value), exps[0]);
        chk("stall_tag", 260'(out_tag), 260'(8));
      end
      step();
    end
    chk("stall_accepted", 260'(accepted), 3);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("stall_drained", 260'(q.size()), 0);
    chk("stall_occ_end", 260'(occupancy), 0);

    // Flush with two operands in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      v = rand_val();
      in_valid = 1'b1; in_value = v[257:0]; in_tag = TAG_W'(c);
      step();
    end
    chk("flush_pre_occ", 260'(occupancy), 2);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 260'(in_ready), 0);
    step();
    chk("flush_occ", 260'(occupancy), 0);
    chk("flush_out_valid", 260'(out_valid), 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    q.delete();
    repeat (4) step();
    chk("flush_no_out", 260'(occupancy), 0);

    // Random stream with backpressure and a mid-stream reset pulse.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 260'(out_valid), 0);
        chk("midrst_occ", 260'(occupancy), 0);
        q.delete();
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 260'(in_ready), 1);
      end
      case ($urandom % 8)
        0: v = PM;
        1: v = PM - 1;
        2: v = PM + 1;
        3: v = (260'(1) << 258) - 1;
        4: v = (260'($urandom % 16) << W) + 260'($urandom % 64);
        default: v = rand_val();
      endcase
      in_valid  = ($urandom % 4) != 0;
      in_value  = v[257:0];
      in_full   = $urandom % 2;
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom % 4) != 0;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("final_drained", 260'(q.size()), 0);
    chk("final_occ", 260'(occupancy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
